ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the MIPS32 pipeline. It sits directly downstream of the ID/EX pipeline register and consumes that register's outputs.
- Computes the ALU result, owns the HI/LO registers and an iterative signed multiplier, and registers everything into the EX/MEM boundary.
- While a multiply runs it raises a stall that holds the ID/EX register and earlier stages.

Parameters:
RADIX_BITS, 1, multiplier bits retired per BUSY cycle (legal: 1, 2, 4); N = 32/RADIX_BITS BUSY cycles.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
ivalid  in  1  ID/EX slot holds a real instruction
iPC  in  32  instruction PC
iIR  in  32  instruction word (shamt = iIR[10:6])
iread_data1  in  32  rs value
iread_data2  in  32  rt value
isign_ext  in  32  sign-extended immediate
ialuop  in  4  operation select
ialusrc  in  1  1: B = isign_ext, 0: B = iread_data2
imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write  in  1 each  control bits carried to MEM/WB
iwrite_addr  in  5  destination register
iflush  in  1  kill the EX slot (branch/jump redirect)
ostall  out  1  hold ID/EX and earlier stages
ovalid  out  1  EX/MEM slot valid
oPC, oIR  out  32 each  passed through
oalu_result  out  32  ALU/HI/LO result
ostore_data  out  32  registered iread_data2
owrite_addr  out  5  passed through
omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write  out  1 each  passed through

Behaviour:
- reset (sync, high): every output register = 0, HI = LO = 0, FSM in IDLE. reset overrides iflush and all other inputs.
- Operand A = iread_data1. Operand B = ialusrc ? isign_ext : iread_data2.
- ialuop encoding:
  - 0000 AND, 0001 OR, 0011 XOR, 1100 NOR
  - 0010 ADD, 0110 SUB: 32-bit wrap, no overflow trap
  - 0111 SLT: signed, result 1 or 0
  - 0100 SLL, 0101 SRL: operate on B by shamt
  - 1000 MULT, 1001 MFHI, 1010 MFLO
  - 1011 DIVU: see Optional Feature
  - Any other code: result 0.
- Non-multicycle op, FSM IDLE, no flush: single-cycle latency. The next edge registers the result and all pass-through fields, with ovalid = ivalid.
- FSM states:
  - IDLE: if ivalid and ialuop = MULT, latch |A|, |B| and the sign, set count = N, go to BUSY. ostall = 1 combinationally in this cycle. A bubble is registered (ovalid = 0, all control outputs 0).
  - BUSY: each cycle retire RADIX_BITS multiplier bits with shift-add and decrement count; ostall = 1; a bubble is registered. When count reaches 1, write the sign-corrected 64-bit product to HI:LO and go to DONE.
  - DONE: ostall = 0. The MULT still present on the inputs is retired to EX/MEM with ovalid = 1, oreg_write = 0, oalu_result = LO. Go to IDLE.
- MULT occupancy: N+2 cycles. MFHI/MFLO entering the cycle after DONE sees the new HI/LO.
- MFHI/MFLO in IDLE: return current HI/LO with no stall.
- iflush:
  - Registers a bubble this edge: ovalid and all control outputs 0.
  - Forces the FSM to IDLE, aborting any multiply; HI/LO are left unchanged.
  - ostall = 0 in the cycle iflush is high.
- iflush and a MULT start in the same cycle: the flush wins and no multiply starts.
- ivalid = 0: a bubble is registered and the FSM is not started.

Optional Feature:
- Macro EX_DIV_EN.
- Defined: ialuop 1011 = DIVU. Unsigned restoring division uses the same FSM and N cycles, giving LO = quotient, HI = remainder. Divide by zero gives LO = 32'hFFFFFFFF, HI = dividend, with the same timing.
- Undefined: 1011 is treated as an unknown op (single cycle, result 0), with no stall and HI/LO untouched.

Test Plan:
- Reset: assert reset for 2 cycles with garbage inputs -> all outputs 0, ostall 0; MFHI afterwards returns 0.
- ADD/SLT: A = 32'h7FFFFFFF, B = 1, op ADD -> oalu_result 32'h80000000 one cycle later. Then SLT with A = -1, B = 1 -> 1.
- MULT, RADIX_BITS = 1: A = -3, B = 7 -> ostall high for 33 cycles, then DONE. A following MFHI -> 32'hFFFFFFFF and MFLO -> 32'hFFFFFFEB.
- Immediate/shift: ialusrc = 1, isign_ext = 32'hFFFF8000, op OR with A = 0 -> 32'hFFFF8000. SLL with B = 1, shamt 31 -> 32'h80000000.
- Flush: iflush raised on the 5th BUSY cycle -> ostall 0 that cycle, bubble registered, HI/LO keep their prior values, FSM returns to IDLE.
- EX_DIV_EN: DIVU 100/7 -> LO 14, HI 2. DIVU 5/0 -> LO 32'hFFFFFFFF, HI 5. With the macro off, DIVU gives result 0 and no stall.

Source files
------------

// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// ex_stage_if: bundles the ID/EX inputs and EX/MEM outputs of the execute stage.
//   master : upstream/downstream side (drives the i* fields, observes o*)
//   slave  : the execute stage itself (observes i*, drives o*)
// Fields:
//   ivalid, iPC, iIR, iread_data1, iread_data2, isign_ext, ialuop, ialusrc,
//   imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write, iwrite_addr,
//   iflush                                  -> into the stage
//   ostall, ovalid, oPC, oIR, oalu_result, ostore_data, owrite_addr,
//   omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write
//                                           <- out of the stage
// ---------------------------------------------------------------------------
interface ex_stage_if;
  logic        ivalid;
  logic [31:0] iPC;
  logic [31:0] iIR;
  logic [31:0] iread_data1;
  logic [31:0] iread_data2;
  logic [31:0] isign_ext;
  logic [3:0]  ialuop;
  logic        ialusrc;
  logic        imem_read;
  logic        imem_write;
  logic        imem_to_reg;
  logic        ipc_to_reg;
  logic        ireg_write;
  logic [4:0]  iwrite_addr;
  logic        iflush;

  logic        ostall;
  logic        ovalid;
  logic [31:0] oPC;
  logic [31:0] oIR;
  logic [31:0] oalu_result;
  logic [31:0] ostore_data;
  logic [4:0]  owrite_addr;
  logic        omem_read;
  logic        omem_write;
  logic        omem_to_reg;
  logic        opc_to_reg;
  logic        oreg_write;

  modport master (
    output ivalid, iPC, iIR, iread_data1, iread_data2, isign_ext, ialuop, ialusrc,
           imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write, iwrite_addr, iflush,
    input  ostall, ovalid, oPC, oIR, oalu_result, ostore_data, owrite_addr,
           omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write
  );

  modport slave (
    input  ivalid, iPC, iIR, iread_data1, iread_data2, isign_ext, ialuop, ialusrc,
           imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write, iwrite_addr, iflush,
    output ostall, ovalid, oPC, oIR, oalu_result, ostore_data, owrite_addr,
           omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write
  );
endinterface

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage: MIPS32 execute stage. Computes the ALU result, owns HI/LO and an
// iterative signed multiplier (RADIX_BITS multiplier bits per cycle), and
// registers everything into the EX/MEM boundary.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   ex    : ex_stage_if.slave, ID/EX inputs and EX/MEM outputs (+ ostall)
// Parameter:
//   RADIX_BITS : 1, 2 or 4; a multicycle op spends 32/RADIX_BITS BUSY cycles.
// Build option:
//   EX_DIV_EN  : when defined, aluop 4'b1011 is DIVU (unsigned restoring
//                divide on the same FSM); otherwise 4'b1011 yields 0.
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int RADIX_BITS = 1
) (
  input  logic      clock,
  input  logic      reset,
  ex_stage_if.slave ex
);

  localparam int         N     = 32 / RADIX_BITS;
  localparam logic [5:0] N_CNT = 6'(N);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_MFHI = 4'b1001;
  localparam logic [3:0] OP_MFLO = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef EX_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;   // multiplicand (low word = divisor when dividing)
  logic [31:0] mplier_q, mplier_d; // multiplier (dividend/quotient when dividing)
  logic [63:0] acc_q, acc_d;       // partial product (low word = remainder when dividing)
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
`ifdef EX_DIV_EN
  logic        is_div_q, is_div_d;
`endif

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, alu_q, alu_d, store_q, store_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d, pc_to_reg_q, pc_to_reg_d;
  logic        reg_write_q, reg_write_d;

  logic [31:0] op_a_s, op_b_s, alu_res_s, abs_a_s, abs_b_s;
  logic [4:0]  shamt_s;
  logic        is_mc_op_s, is_div_op_s, start_s;
  logic        stall_s, bubble_s, retire_s;
  logic [63:0] pp_s, acc_step_s, prod_s;
  logic [31:0] fin_hi_s, fin_lo_s;

  assign op_a_s  = ex.iread_data1;
  assign op_b_s  = ex.ialusrc ? ex.isign_ext : ex.iread_data2;
  assign shamt_s = ex.iIR[10:6];
  assign abs_a_s = op_a_s[31] ? (32'd0 - op_a_s) : op_a_s;
  assign abs_b_s = op_b_s[31] ? (32'd0 - op_b_s) : op_b_s;

`ifdef EX_DIV_EN
  assign is_div_op_s = (ex.ialuop == OP_DIVU);
`else
  assign is_div_op_s = 1'b0;
`endif
  assign is_mc_op_s = (ex.ialuop == OP_MULT) | is_div_op_s;
  assign start_s    = ex.ivalid & is_mc_op_s;

  // Single-cycle ALU result for the instruction currently on the inputs.
  always_comb begin
    alu_res_s = 32'd0;
    case (ex.ialuop)
      OP_AND:  alu_res_s = op_a_s & op_b_s;
      OP_OR:   alu_res_s = op_a_s | op_b_s;
      OP_XOR:  alu_res_s = op_a_s ^ op_b_s;
      OP_NOR:  alu_res_s = ~(op_a_s | op_b_s);
      OP_ADD:  alu_res_s = op_a_s + op_b_s;
      OP_SUB:  alu_res_s = op_a_s - op_b_s;
      OP_SLT:  alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ? 32'd1 : 32'd0;
      OP_SLL:  alu_res_s = op_b_s << shamt_s;
      OP_SRL:  alu_res_s = op_b_s >> shamt_s;
      OP_MFHI: alu_res_s = hi_q;
      OP_MFLO: alu_res_s = lo_q;
      default: alu_res_s = 32'd0;
    endcase
  end

  // One shift-add step over RADIX_BITS multiplier bits, plus sign-corrected product.
  always_comb begin
    pp_s = 64'd0;
    for (int j = 0; j < RADIX_BITS; j++) begin
      if (mplier_q[j]) begin
        pp_s = pp_s + (mcand_q << j);
      end else begin
        pp_s = pp_s;
      end
    end
    acc_step_s = acc_q + pp_s;
    if (neg_q) begin
      prod_s = ~acc_step_s + 64'd1;
    end else begin
      prod_s = acc_step_s;
    end
  end

`ifdef EX_DIV_EN
  logic [32:0] rem_s, dvs_s;
  logic [31:0] quo_s;

  // RADIX_BITS restoring-division steps. A zero divisor always "fits", so the
  // quotient fills with ones and the remainder collects the whole dividend.
  always_comb begin
    rem_s = {1'b0, acc_q[31:0]};
    quo_s = mplier_q;
    dvs_s = {1'b0, mcand_q[31:0]};
    for (int j = 0; j < RADIX_BITS; j++) begin
      rem_s = {rem_s[31:0], quo_s[31]};
      quo_s = {quo_s[30:0], 1'b0};
      if (rem_s >= dvs_s) begin
        rem_s    = rem_s - dvs_s;
        quo_s[0] = 1'b1;
      end else begin
        rem_s = rem_s;
      end
    end
  end

  assign fin_hi_s = is_div_q ? rem_s[31:0] : prod_s[63:32];
  assign fin_lo_s = is_div_q ? quo_s       : prod_s[31:0];
`else
  assign fin_hi_s = prod_s[63:32];
  assign fin_lo_s = prod_s[31:0];
`endif

  // Multicycle FSM: next state, datapath registers, stall and bubble control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef EX_DIV_EN
    is_div_d = is_div_q;
`endif
    stall_s  = 1'b0;
    bubble_s = ~ex.ivalid;
    retire_s = 1'b0;
    alu_d    = alu_res_s;
    if (ex.iflush) begin
      // Flush wins over everything except reset; HI/LO keep their values.
      state_d  = S_IDLE;
      bubble_s = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
            state_d  = S_BUSY;
            cnt_d    = N_CNT;
            acc_d    = 64'd0;
            mcand_d  = {32'd0, abs_a_s};
            mplier_d = abs_b_s;
            neg_d    = op_a_s[31] ^ op_b_s[31];
`ifdef EX_DIV_EN
            is_div_d = is_div_op_s;
            if (is_div_op_s) begin
              mcand_d  = {32'd0, op_b_s};
              mplier_d = op_a_s;
              neg_d    = 1'b0;
            end else begin
              is_div_d = 1'b0;
            end
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          cnt_d    = cnt_q - 6'd1;
          mcand_d  = mcand_q << RADIX_BITS;
          mplier_d = mplier_q >> RADIX_BITS;
          acc_d    = acc_step_s;
`ifdef EX_DIV_EN
          if (is_div_q) begin
            mcand_d  = mcand_q;
            mplier_d = quo_s;
            acc_d    = {32'd0, rem_s[31:0]};
          end else begin
            mcand_d  = mcand_q << RADIX_BITS;
          end
`endif
          if (cnt_q == 6'd1) begin
            state_d = S_DONE;
            hi_d    = fin_hi_s;
            lo_d    = fin_lo_s;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_DONE: begin
          // The multicycle op still sitting on the inputs retires now.
          retire_s = 1'b1;
          bubble_s = 1'b0;
          alu_d    = lo_q;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // EX/MEM next values: data fields pass through, control bits gated by bubble.
  always_comb begin
    valid_d = ~bubble_s;
    pc_d    = ex.iPC;
    ir_d    = ex.iIR;
    store_d = ex.iread_data2;
    waddr_d = ex.iwrite_addr;
    if (bubble_s) begin
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      pc_to_reg_d  = 1'b0;
      reg_write_d  = 1'b0;
    end else begin
      mem_read_d   = ex.imem_read;
      mem_write_d  = ex.imem_write;
      mem_to_reg_d = ex.imem_to_reg;
      pc_to_reg_d  = ex.ipc_to_reg;
      reg_write_d  = ex.ireg_write & ~retire_s;
    end
  end

  // State, HI/LO, multiplier and EX/MEM registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 6'd0;
      mcand_q      <= 64'd0;
      mplier_q     <= 32'd0;
      acc_q        <= 64'd0;
      neg_q        <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
`ifdef EX_DIV_EN
      is_div_q     <= 1'b0;
`endif
      valid_q      <= 1'b0;
      pc_q         <= 32'd0;
      ir_q         <= 32'd0;
      alu_q        <= 32'd0;
      store_q      <= 32'd0;
      waddr_q      <= 5'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_to_reg_q  <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
`ifdef EX_DIV_EN
      is_div_q     <= is_div_d;
`endif
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      alu_q        <= alu_d;
      store_q      <= store_d;
      waddr_q      <= waddr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_to_reg_q  <= pc_to_reg_d;
      reg_write_q  <= reg_write_d;
    end
  end

  // Stall is combinational so the upstream register holds in the same cycle.
  assign ex.ostall      = stall_s & ~reset;
  assign ex.ovalid      = valid_q;
  assign ex.oPC         = pc_q;
  assign ex.oIR         = ir_q;
  assign ex.oalu_result = alu_q;
  assign ex.ostore_data = store_q;
  assign ex.owrite_addr = waddr_q;
  assign ex.omem_read   = mem_read_q;
  assign ex.omem_write  = mem_write_q;
  assign ex.omem_to_reg = mem_to_reg_q;
  assign ex.opc_to_reg  = pc_to_reg_q;
  assign ex.oreg_write  = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  localparam int RADIX = 1;
  localparam int NCYC  = 32 / RADIX;

  logic clock = 1'b0;
  logic reset;

  ex_stage_if bus ();

  ex_stage #(.RADIX_BITS(RADIX)) dut (
    .clock(clock),
    .reset(reset),
    .ex   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        regw;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] pc_ctr   = 32'h0040_0000;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every valid EX/MEM slot is matched against the oldest expectation.
  exp_t m_e;
  always @(negedge clock) begin
    if (!reset && bus.ovalid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got pc %h alu %h at cycle %0d, expected no valid slot",
                 bus.oPC, bus.oalu_result, cyc);
      end else begin
        m_e = sb.pop_front();
        if (bus.oalu_result !== m_e.alu || bus.oPC !== m_e.pc ||
            bus.oreg_write !== m_e.regw || cyc != m_e.cyc) begin
          n_fail++;
          $display("FAIL %s: got alu %h pc %h regw %b cycle %0d, expected alu %h pc %h regw %b cycle %0d",
                   m_e.nm, bus.oalu_result, bus.oPC, bus.oreg_write, cyc,
                   m_e.alu, m_e.pc, m_e.regw, m_e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic src, input logic [31:0] imm,
                       input logic [4:0] sh, input logic fl);
    bus.ivalid      = v;
    bus.ialuop      = op;
    bus.iread_data1 = a;
    bus.iread_data2 = b;
    bus.ialusrc     = src;
    bus.isign_ext   = imm;
    bus.iIR         = {21'd0, sh, 6'd0};
    bus.iPC         = pc_ctr;
    bus.iflush      = fl;
    bus.imem_read   = 1'b0;
    bus.imem_write  = 1'b0;
    bus.imem_to_reg = 1'b0;
    bus.ipc_to_reg  = 1'b0;
    bus.ireg_write  = 1'b1;
    bus.iwrite_addr = 5'd3;
  endtask

  task automatic push(input string nm, input logic [31:0] alu, input logic regw, input int c);
    exp_t e;
    e.nm = nm; e.alu = alu; e.pc = pc_ctr; e.regw = regw; e.cyc = c;
    sb.push_back(e);
  endtask

  // Single-cycle op: result must appear exactly one edge later.
  task automatic op1(input string nm, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic src, input logic [31:0] imm,
                     input logic [4:0] sh, input logic [31:0] exp_alu);
    drive(1'b1, op, a, b, src, imm, sh, 1'b0);
    push(nm, exp_alu, 1'b1, cyc + 1);
    @(posedge clock); #1;
    pc_ctr += 32'd4;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // Multicycle op held on the inputs while stalled; retires with LO, no reg write.
  task automatic mc(input string nm, input logic [3:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_lo);
    int stalls;
    stalls = 0;
    drive(1'b1, op, a, b, 1'b0, 32'd0, 5'd0, 1'b0);
    push(nm, exp_lo, 1'b0, cyc + NCYC + 2);
    @(negedge clock);
    while (bus.ostall === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clock);
    end
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'(NCYC + 1));
    @(posedge clock); #1;
    pc_ctr += 32'd4;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with garbage (including a MULT) on the inputs.
    reset = 1'b1;
    drive(1'b1, 4'b1000, $urandom, $urandom, 1'b1, $urandom, 5'd7, 1'b0);
    bus.imem_read  = 1'b1;
    bus.imem_write = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ovalid", {31'd0, bus.ovalid}, 32'd0);
    chk("reset_alu", bus.oalu_result, 32'd0);
    chk("reset_pc", bus.oPC, 32'd0);
    chk("reset_ctrl", {27'd0, bus.omem_read, bus.omem_write, bus.omem_to_reg,
                       bus.opc_to_reg, bus.oreg_write}, 32'd0);
    chk("reset_ostall", {31'd0, bus.ostall}, 32'd0);
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    op1("mfhi_after_reset", 4'b1001, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'd0);

    // ALU operations.
    op1("add_wrap",  4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd0, 32'h8000_0000);
    op1("slt_true",  4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd0, 32'd1);
    op1("slt_false", 4'b0111, 32'd5, 32'd3, 1'b0, 32'd0, 5'd0, 32'd0);
    op1("sub_wrap",  4'b0110, 32'd5, 32'd7, 1'b0, 32'd0, 5'd0, 32'hFFFF_FFFE);
    op1("or_imm",    4'b0001, 32'd0, 32'h1234_5678, 1'b1, 32'hFFFF_8000, 5'd0, 32'hFFFF_8000);
    op1("sll_31",    4'b0100, 32'hDEAD_BEEF, 32'd1, 1'b0, 32'd0, 5'd31, 32'h8000_0000);
    op1("srl_4",     4'b0101, 32'd0, 32'hF000_0000, 1'b0, 32'd0, 5'd4, 32'h0F00_0000);
    op1("and",       4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'd0, 5'd0, 32'h0F00_0F00);
    op1("xor",       4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'd0, 5'd0, 32'hF0F0_F0F0);
    op1("nor",       4'b1100, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'd0, 5'd0, 32'h000F_000F);
    op1("unknown",   4'b1111, 32'd5, 32'd6, 1'b0, 32'd0, 5'd0, 32'd0);
    idle(2);

    // Signed multiply -3 * 7 = -21.
    mc("mult_m3x7", 4'b1000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    op1("mfhi_mult", 4'b1001, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    op1("mflo_mult", 4'b1010, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'hFFFF_FFEB);

    // Flush on the 5th BUSY cycle aborts the multiply.
    drive(1'b1, 4'b1000, 32'd2, 32'd3, 1'b0, 32'd0, 5'd0, 1'b0);
    repeat (4) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("busy4_ostall", {31'd0, bus.ostall}, 32'd1);
    @(posedge clock); #1;
    bus.iflush = 1'b1;
    @(negedge clock);
    chk("flush_ostall", {31'd0, bus.ostall}, 32'd0);
    @(posedge clock); #1;
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    @(negedge clock);
    chk("flush_bubble", {31'd0, bus.ovalid}, 32'd0);
    @(posedge clock); #1;
    op1("mfhi_kept", 4'b1001, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    op1("mflo_kept", 4'b1010, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'hFFFF_FFEB);

    // Flush together with a MULT start: no multiply begins.
    drive(1'b1, 4'b1000, 32'd2, 32'd3, 1'b0, 32'd0, 5'd0, 1'b1);
    @(negedge clock);
    chk("flush_start_ostall", {31'd0, bus.ostall}, 32'd0);
    @(posedge clock); #1;
    pc_ctr += 32'd4;
    op1("add_after_flush", 4'b0010, 32'd2, 32'd3, 1'b0, 32'd0, 5'd0, 32'd5);

`ifdef EX_DIV_EN
    mc("divu_100_7", 4'b1011, 32'd100, 32'd7, 32'd14);
    op1("divu_rem", 4'b1001, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'd2);
    mc("divu_5_0", 4'b1011, 32'd5, 32'd0, 32'hFFFF_FFFF);
    op1("divz_rem", 4'b1001, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'd5);
`else
    drive(1'b1, 4'b1011, 32'd100, 32'd7, 1'b0, 32'd0, 5'd0, 1'b0);
    push("divu_off", 32'd0, 1'b1, cyc + 1);
    @(negedge clock);
    chk("divu_off_ostall", {31'd0, bus.ostall}, 32'd0);
    @(posedge clock); #1;
    pc_ctr += 32'd4;
    op1("mflo_after_divu_off", 4'b1010, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'hFFFF_FFEB);
`endif

    idle(3);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
